div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 130 +++++++++++++
 tb/tb_div.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider (signed/unsigned), one quotient bit per cycle.
// Result is {remainder, quotient}; outputs are fully registered.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;   // dividend magnitude, shifted out MSB-first as quotient shifts in
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_d;
    logic        ready_d;

    logic [32:0] shifted;
    logic [33:0] trial;
    logic        trial_ge;
    logic [31:0] fin_quo, fin_rem;

    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        trial    = {1'b0, shifted} - {2'b00, dvs_q};
        trial_ge = ~trial[33];
        fin_quo  = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        fin_rem  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_o;
        ready_d   = ready_o;

        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d = signed_div_i && opdata1_i[31];
                    quo_d     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
                    dvs_d     = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != 6'd32) begin
                    // a failed trial keeps the plain shift; shifted[32] is 0 in that case
                    rem_d = trial_ge ? trial[31:0] : shifted[31:0];
                    quo_d = {quo_q[30:0], trial_ge};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = END;
                    result_d = {fin_rem, fin_quo};
                    ready_d  = 1'b1;
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_o  <= result_d;
            ready_o   <= ready_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: a vector table of divisions plus hand sequences
// for annul, mid-operation reset and held-start behaviour.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int unsigned checks;
    int unsigned failures;

    div dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div),
        .opdata1_i   (op1),
        .opdata2_i   (op2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int unsigned lat;
        int unsigned hold;
    } vec_t;

    vec_t vecs[10];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start held until ready; operands are scrambled right after acceptance.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int unsigned lat, input int unsigned hold);
        int unsigned n;
        bit seen;
        @(negedge clk);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
        @(posedge clk);
        #1;
        op1 = 32'h5A5A5A5A; op2 = 32'h00000003; signed_div = ~sgn;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (ready) seen = 1;
        end
        check_int({name, "_latency"}, n, lat);
        check64({name, "_result"}, result, exp);
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check64({name, "_hold_ready"}, {63'd0, ready}, 64'd1);
            check64({name, "_hold_result"}, result, exp);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check64({name, "_release_ready"}, {63'd0, ready}, 64'd0);
        check64({name, "_release_result"}, result, 64'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;

        vecs[0] = '{"u100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 0};
        vecs[1] = '{"s_m7_2",   1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33, 0};
        vecs[2] = '{"u_byzero", 1'b0, 32'd12345,      32'd0,          64'h0,                 1,  0};
        vecs[3] = '{"s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0};
        vecs[4] = '{"u_big_2",  1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33, 0};
        vecs[5] = '{"s_m100_m7",1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33, 0};
        vecs[6] = '{"u3_10",    1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 33, 0};
        vecs[7] = '{"u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 0};
        vecs[8] = '{"s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 5};
        vecs[9] = '{"s_byzero", 1'b1, 32'hFFFFFFFF,   32'd0,          64'h0,                 1,  2};

        #12;
        check64("reset_ready", {63'd0, ready}, 64'd0);
        check64("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int unsigned i = 0; i < 10; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold);

        // Annul after 10 iterations; ready must never rise for that operation.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        for (int unsigned i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            check64("annul_no_ready", {63'd0, ready}, 64'd0);
            check64("annul_no_result", result, 64'd0);
        end
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        run_div("after_annul", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 0);

        // Annul while in BYZERO.
        @(negedge clk);
        op1 = 32'd5; op2 = 32'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check64("annul_byzero_ready", {63'd0, ready}, 64'd0);
        end
        @(negedge clk);
        annul = 1'b0; start = 1'b0;

        // Reset at iteration 20, then a fresh 9/3 accepted on the first edge after release.
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check64("rst_mid_ready", {63'd0, ready}, 64'd0);
        check64("rst_mid_result", result, 64'd0);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        run_div("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

        // Reset while a result is being presented must clear outputs without a clock edge.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        begin
            int unsigned n;
            n = 0;
            while (!ready && n < 40) begin
                @(posedge clk);
                n++;
                #1;
            end
            check64("end_pre_rst_result", result, 64'h00000002_0000000E);
        end
        #2;
        rst = 1'b0;
        #1;
        check64("rst_end_ready", {63'd0, ready}, 64'd0);
        check64("rst_end_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check64("post_rst_idle_ready", {63'd0, ready}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
